arcade_input_ctrl: RTL and testbench

//  Input conditioner between the USB/DB9/DB15 joystick merge and the arcade core (clk_sys domain).

---
 rtl/arcade_input_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_arcade_input_ctrl.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/arcade_input_ctrl.sv
// arcade_input_ctrl
// Input conditioner between the joystick merge and the arcade core (clk domain).
// Synchronises and debounces player buttons, turns coin presses into fixed-width
// coin-mech pulses, owns the user pause toggle, merges the pause sources and
// drives the dim-video timer.
//
// Ports
//   clk           in   system clock
//   reset         in   asynchronous, active-high reset
//   joy_in[7:0]   in   raw {jump2,fire2,jump1,fire1,up,down,left,right}
//   start_in[1:0] in   raw {start2,start1}
//   coin_in[1:0]  in   raw {coin2,coin1}
//   pause_btn     in   raw pause button
//   osd_open      in   OSD visible
//   osd_pause_en  in   pause while OSD is open
//   hs_access     in   hiscore module owns core RAM
//   joy_out[7:0]  out  debounced joy_in
//   start_out[1:0]out  debounced start_in
//   coin_out[1:0] out  per-slot coin pulses
//   pause         out  core pause request
//   pause_user    out  user pause toggle state
//   dim_video     out  halve RGB
//
// Coin slot FSM
//   state   | meaning
//   C_IDLE  | waiting for a debounced coin rising edge while not paused
//   C_PULSE | coin_out high, timing the pulse width
//   C_GAP   | coin_out low, enforcing minimum gap before the next pulse
module arcade_input_ctrl #(
    parameter int unsigned DB_CYCLES   = 16,
    parameter int unsigned COIN_PULSE  = 3000000,
    parameter int unsigned COIN_GAP    = 3000000,
    parameter logic [31:0] DIM_TIMEOUT = 32'h11E1A300
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] joy_in,
    input  logic [1:0] start_in,
    input  logic [1:0] coin_in,
    input  logic       pause_btn,
    input  logic       osd_open,
    input  logic       osd_pause_en,
    input  logic       hs_access,
    output logic [7:0] joy_out,
    output logic [1:0] start_out,
    output logic [1:0] coin_out,
    output logic       pause,
    output logic       pause_user,
    output logic       dim_video
);

    localparam int NB  = 13;
    localparam int DBW = (DB_CYCLES > 2) ? $clog2(DB_CYCLES) : 1;
    localparam logic [DBW-1:0] DB_LAST    = DBW'(DB_CYCLES - 1);
    localparam logic [31:0]    PULSE_LAST = 32'(COIN_PULSE - 1);
    localparam logic [31:0]    GAP_LAST   = 32'(COIN_GAP - 1);

    typedef enum logic [1:0] {C_IDLE, C_PULSE, C_GAP} coin_state_e;

    logic [NB-1:0]  raw;
    logic [NB-1:0]  sync1_q, sync2_q;
    logic [NB-1:0]  deb_q, deb_d;
    logic [DBW-1:0] cnt_q [NB];
    logic [DBW-1:0] cnt_d [NB];

    logic [1:0]     dc;
    logic           dp;
    logic [1:0]     dc_prev_q;
    logic           dp_prev_q;

    coin_state_e    st_q [2];
    coin_state_e    st_d [2];
    logic [31:0]    tmr_q [2];
    logic [31:0]    tmr_d [2];
    logic [1:0]     coin_q, coin_d;

    logic           pause_user_q, pause_user_d;
    logic           pause_q, pause_d;
    logic [31:0]    dim_tmr_q, dim_tmr_d;
    logic           dim_q, dim_d;

    // Bit order shared by sync, debounce and the output slices below.
    assign raw = {pause_btn, coin_in, start_in, joy_in};
    assign dc  = deb_q[11:10];
    assign dp  = deb_q[12];

    always_comb begin
        deb_d = deb_q;
        for (int i = 0; i < NB; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == DB_LAST) begin
                    deb_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        coin_d = coin_q;
        for (int s = 0; s < 2; s++) begin
            st_d[s]  = st_q[s];
            tmr_d[s] = tmr_q[s];
            case (st_q[s])
                C_IDLE: begin
                    // Edges while paused are dropped, not remembered.
                    if (dc[s] && !dc_prev_q[s] && !pause_q) begin
                        st_d[s]   = C_PULSE;
                        coin_d[s] = 1'b1;
                        tmr_d[s]  = '0;
                    end
                end
                C_PULSE: begin
                    if (tmr_q[s] == PULSE_LAST) begin
                        st_d[s]   = C_GAP;
                        coin_d[s] = 1'b0;
                        tmr_d[s]  = '0;
                    end else begin
                        tmr_d[s] = tmr_q[s] + 32'd1;
                    end
                end
                C_GAP: begin
                    if (tmr_q[s] == GAP_LAST) begin
                        st_d[s]  = C_IDLE;
                        tmr_d[s] = '0;
                    end else begin
                        tmr_d[s] = tmr_q[s] + 32'd1;
                    end
                end
                default: begin
                    st_d[s]   = C_IDLE;
                    coin_d[s] = 1'b0;
                    tmr_d[s]  = '0;
                end
            endcase
        end
    end

    always_comb begin
        pause_user_d = pause_user_q ^ (dp & ~dp_prev_q);
        pause_d      = pause_user_q | hs_access | (osd_open & osd_pause_en);
        dim_tmr_d    = '0;
        if (pause_user_q) begin
            dim_tmr_d = (dim_tmr_q >= DIM_TIMEOUT) ? dim_tmr_q : dim_tmr_q + 32'd1;
        end
        // Derived from the next timer value so dim drops together with the clear.
        dim_d = (dim_tmr_d >= DIM_TIMEOUT);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync1_q      <= '0;
            sync2_q      <= '0;
            deb_q        <= '0;
            for (int i = 0; i < NB; i++) cnt_q[i] <= '0;
            dc_prev_q    <= '0;
            dp_prev_q    <= 1'b0;
            for (int s = 0; s < 2; s++) begin
                st_q[s]  <= C_IDLE;
                tmr_q[s] <= '0;
            end
            coin_q       <= '0;
            pause_user_q <= 1'b0;
            pause_q      <= 1'b0;
            dim_tmr_q    <= '0;
            dim_q        <= 1'b0;
        end else begin
            sync1_q      <= raw;
            sync2_q      <= sync1_q;
            deb_q        <= deb_d;
            for (int i = 0; i < NB; i++) cnt_q[i] <= cnt_d[i];
            dc_prev_q    <= dc;
            dp_prev_q    <= dp;
            for (int s = 0; s < 2; s++) begin
                st_q[s]  <= st_d[s];
                tmr_q[s] <= tmr_d[s];
            end
            coin_q       <= coin_d;
            pause_user_q <= pause_user_d;
            pause_q      <= pause_d;
            dim_tmr_q    <= dim_tmr_d;
            dim_q        <= dim_d;
        end
    end

    assign joy_out    = deb_q[7:0];
    assign start_out  = deb_q[9:8];
    assign coin_out   = coin_q;
    assign pause      = pause_q;
    assign pause_user = pause_user_q;
    assign dim_video  = dim_q;

endmodule

// File: tb/tb_arcade_input_ctrl.sv
// Directed bench for arcade_input_ctrl with small timing parameters.
// Per-edge observations are packed into 64-bit vectors (bit i = value after
// clock edge i of a sequence) and compared against hand-computed masks.
module tb_arcade_input_ctrl;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] joy_in = '0;
    logic [1:0] start_in = '0;
    logic [1:0] coin_in = '0;
    logic       pause_btn = 1'b0;
    logic       osd_open = 1'b0;
    logic       osd_pause_en = 1'b0;
    logic       hs_access = 1'b0;
    logic [7:0] joy_out;
    logic [1:0] start_out;
    logic [1:0] coin_out;
    logic       pause;
    logic       pause_user;
    logic       dim_video;

    int n_checks = 0;
    int n_fail   = 0;

    logic [63:0] obs_c0, obs_c1, obs_pu, obs_p, obs_dim, obs_j0;

    arcade_input_ctrl #(
        .DB_CYCLES  (4),
        .COIN_PULSE (8),
        .COIN_GAP   (4),
        .DIM_TIMEOUT(32'd20)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .joy_in      (joy_in),
        .start_in    (start_in),
        .coin_in     (coin_in),
        .pause_btn   (pause_btn),
        .osd_open    (osd_open),
        .osd_pause_en(osd_pause_en),
        .hs_access   (hs_access),
        .joy_out     (joy_out),
        .start_out   (start_out),
        .coin_out    (coin_out),
        .pause       (pause),
        .pause_user  (pause_user),
        .dim_video   (dim_video)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] rng(input int a, input int b);
        logic [63:0] v;
        v = '0;
        for (int i = a; i <= b; i++) v[i] = 1'b1;
        return v;
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Raw stimulus bit i is the input level presented to clock edge i.
    task automatic run(input logic [63:0] c0, input logic [63:0] c1,
                       input logic [63:0] pb, input int n);
        obs_c0 = '0; obs_c1 = '0; obs_pu = '0; obs_p = '0; obs_dim = '0; obs_j0 = '0;
        coin_in   = {c1[1], c0[1]};
        pause_btn = pb[1];
        for (int i = 1; i <= n; i++) begin
            @(posedge clk);
            #1;
            obs_c0[i]  = coin_out[0];
            obs_c1[i]  = coin_out[1];
            obs_pu[i]  = pause_user;
            obs_p[i]   = pause;
            obs_dim[i] = dim_video;
            obs_j0[i]  = joy_out[0];
            if (i < 63) begin
                coin_in   = {c1[i+1], c0[i+1]};
                pause_btn = pb[i+1];
            end
        end
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({joy_out, start_out, coin_out, pause, pause_user, dim_video});
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tick(3);
        check("reset_outputs", all_outs(), 64'd0);
        reset = 1'b0;

        // Debounce latency and glitch rejection
        joy_in[0] = 1'b1;
        tick(5);
        check("joy0_before_6", 64'(joy_out[0]), 64'd0);
        tick(1);
        check("joy0_at_6", 64'(joy_out[0]), 64'd1);
        joy_in[1] = 1'b1;
        tick(3);
        joy_in[1] = 1'b0;
        tick(10);
        check("joy1_glitch", 64'(joy_out[1]), 64'd0);
        start_in = 2'b10;
        tick(6);
        check("start_debounce", 64'(start_out), 64'd2);
        tick(5);

        // Held coin: one 8-clock pulse, other slot untouched
        run(rng(1, 50), 64'd0, 64'd0, 60);
        check("coin0_held", obs_c0, rng(7, 14));
        check("coin1_idle", obs_c1, 64'd0);
        tick(5);

        // Re-press in GAP dropped, later press accepted
        run(rng(1, 4) | rng(11, 20) | rng(31, 40), 64'd0, 64'd0, 60);
        check("coin0_gap_drop", obs_c0, rng(7, 14) | rng(37, 44));
        tick(5);

        // Simultaneous coins
        run(rng(1, 20), rng(1, 20), 64'd0, 40);
        check("coin0_simul", obs_c0, rng(7, 14));
        check("coin1_simul", obs_c1, rng(7, 14));
        tick(5);

        // Pause toggle and dim timer
        run(64'd0, 64'd0, rng(1, 10), 40);
        check("pu_press1", obs_pu, rng(7, 40));
        check("pause_press1", obs_p, rng(8, 40));
        check("dim_press1", obs_dim, rng(27, 40));
        run(64'd0, 64'd0, rng(1, 10), 20);
        check("pu_press2", obs_pu, rng(1, 6));
        check("pause_press2", obs_p, rng(1, 7));
        check("dim_press2", obs_dim, rng(1, 7));
        run(64'd0, 64'd0, rng(1, 10), 40);
        check("pu_press3", obs_pu, rng(7, 40));
        check("pause_press3", obs_p, rng(8, 40));
        check("dim_press3_cleared", obs_dim, rng(27, 40));
        run(64'd0, 64'd0, rng(1, 10), 20);
        check("pu_press4", obs_pu, rng(1, 6));
        tick(5);

        // hiscore access blocks coin and pauses without dimming
        hs_access = 1'b1;
        run(rng(1, 10), 64'd0, 64'd0, 30);
        check("coin0_hs_blocked", obs_c0, 64'd0);
        check("pause_hs", obs_p, rng(1, 30));
        check("dim_hs", obs_dim, 64'd0);
        hs_access = 1'b0;
        tick(5);

        // OSD pause
        osd_open = 1'b1;
        osd_pause_en = 1'b1;
        for (int k = 0; k < 2; k++) begin
            run(64'd0, 64'd0, 64'd0, 60);
            check("pause_osd", obs_p, rng(1, 60));
            check("dim_osd", obs_dim, 64'd0);
            check("pu_osd", obs_pu, 64'd0);
        end
        osd_pause_en = 1'b0;
        run(64'd0, 64'd0, 64'd0, 5);
        check("pause_osd_off", obs_p, 64'd0);
        osd_open = 1'b0;
        tick(5);

        // Reset in the middle of a pulse, inputs held across it
        run(rng(1, 20), 64'd0, 64'd0, 10);
        check("coin0_pre_reset", obs_c0, rng(7, 10));
        reset = 1'b1;
        #1;
        check("reset_async_outputs", all_outs(), 64'd0);
        tick(2);
        reset = 1'b0;
        run(rng(1, 30), 64'd0, 64'd0, 30);
        check("joy0_after_reset", obs_j0, rng(6, 30));
        check("coin0_after_reset", obs_c0, rng(7, 14));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
